// File: rtl/spike_volley_if.sv
// Load/stream bundle between the spike-time producer and the volley encoder.
// The master side presents a vector of spike times and watches the replayed volley.
interface spike_volley_if #(
  parameter int NUM_CHANNELS = 16,
  parameter int TIME_W       = 5
);
  logic                           load_valid;
  logic                           load_ready;
  logic [NUM_CHANNELS*TIME_W-1:0] spike_times;
  logic                           abort;
  logic [TIME_W-1:0]              time_val;
  logic [NUM_CHANNELS-1:0]        spike_volley;
  logic                           volley_active;
  logic                           cycle_done;
  logic                           range_err;

  modport master (
    output load_valid, spike_times, abort,
    input  load_ready, time_val, spike_volley, volley_active, cycle_done, range_err
  );

  modport slave (
    input  load_valid, spike_times, abort,
    output load_ready, time_val, spike_volley, volley_active, cycle_done, range_err
  );
endinterface

// File: rtl/spike_volley_encoder.sv
// Temporal-code transmitter: replays one vector of per-channel spike times as
// single-cycle spikes over a gamma cycle, followed by a quiet rest window.
module spike_volley_encoder #(
  parameter int                NUM_CHANNELS = 16,
  parameter int                TIME_W       = 5,
  parameter int                GAMMA_PERIOD = 16,
  parameter int                REST_CYCLES  = 4,
  parameter logic [TIME_W-1:0] NULL_TIME    = '1
) (
  input logic           clk,
  input logic           rst_n,
  spike_volley_if.slave bus
);
  localparam int                REST_W    = (REST_CYCLES > 1) ? $clog2(REST_CYCLES) : 1;
  localparam logic [TIME_W:0]   GP_WIDE   = (TIME_W+1)'(GAMMA_PERIOD);
  localparam logic [TIME_W-1:0] LAST_STEP = TIME_W'(GAMMA_PERIOD - 1);
  localparam logic [REST_W-1:0] REST_LAST = REST_W'(REST_CYCLES - 1);

  if (GAMMA_PERIOD < 1 || GAMMA_PERIOD > int'(NULL_TIME) || REST_CYCLES < 1) begin : g_param_check
    $error("spike_volley_encoder: need 1 <= GAMMA_PERIOD <= NULL_TIME and REST_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, REST} state_t;

  state_t                         state_q, state_d;
  logic [NUM_CHANNELS*TIME_W-1:0] times_q, times_d;
  logic [TIME_W-1:0]              time_q, time_d;
  logic [NUM_CHANNELS-1:0]        spike_q, spike_d;
  logic                           active_q, active_d;
  logic                           done_q, done_d;
  logic                           err_q, err_d;
  logic [REST_W-1:0]              rest_q, rest_d;

  // A channel fires on step t only if its time is in range and not the "never" code.
  function automatic logic [NUM_CHANNELS-1:0] fires(
    input logic [NUM_CHANNELS*TIME_W-1:0] times,
    input logic [TIME_W-1:0]              t
  );
    logic [NUM_CHANNELS-1:0] m;
    logic [TIME_W-1:0]       ct;
    m = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      ct   = times[i*TIME_W +: TIME_W];
      m[i] = (ct == t) && (ct != NULL_TIME) && ({1'b0, ct} < GP_WIDE);
    end
    return m;
  endfunction

  function automatic logic out_of_range(input logic [NUM_CHANNELS*TIME_W-1:0] times);
    logic          bad;
    logic [TIME_W-1:0] ct;
    bad = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      ct  = times[i*TIME_W +: TIME_W];
      bad = bad | ((ct != NULL_TIME) && ({1'b0, ct} >= GP_WIDE));
    end
    return bad;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d  = state_q;
    times_d  = times_q;
    time_d   = '0;
    spike_d  = '0;
    active_d = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    rest_d   = rest_q;

    unique case (state_q)
      IDLE: begin
        // A simultaneous abort is irrelevant here: the load always wins.
        if (bus.load_valid) begin
          state_d  = RUN;
          times_d  = bus.spike_times;
          spike_d  = fires(bus.spike_times, '0);
          active_d = 1'b1;
          done_d   = (GAMMA_PERIOD == 1);
          err_d    = err_q | out_of_range(bus.spike_times);
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (time_q == LAST_STEP) begin
          state_d = REST;
          rest_d  = '0;
        end else begin
          time_d   = time_q + TIME_W'(1);
          spike_d  = fires(times_q, time_d);
          active_d = 1'b1;
          done_d   = (time_d == LAST_STEP);
        end
      end
      REST: begin
        if (bus.abort || rest_q == REST_LAST) begin
          state_d = IDLE;
        end else begin
          rest_d = rest_q + REST_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the stored times are a handful of flops, so they are reset to NULL_TIME
  // rather than left undefined; a stale vector can never leak into a later volley.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      times_q  <= {NUM_CHANNELS{NULL_TIME}};
      time_q   <= '0;
      spike_q  <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rest_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      times_q  <= times_d;
      time_q   <= time_d;
      spike_q  <= spike_d;
      active_q <= active_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rest_q   <= rest_d;
    end
  end

  assign bus.load_ready    = (state_q == IDLE);
  assign bus.time_val      = time_q;
  assign bus.spike_volley  = spike_q;
  assign bus.volley_active = active_q;
  assign bus.cycle_done    = done_q;
  assign bus.range_err     = err_q;
endmodule

// File: tb/tb_spike_volley_encoder.sv
// Directed bench for spike_volley_encoder: table-driven volleys plus hand-written
// abort, back-to-back and mid-run reset sequences.
module tb_spike_volley_encoder;
  localparam int NC = 16;
  localparam int TW = 5;
  localparam int GP = 16;
  localparam int RC = 4;

  typedef logic [NC*TW-1:0] times_t;

  // Up to three (step, mask) spike events per volley; step -1 means unused.
  typedef struct {
    times_t      times;
    int          t0, t1, t2;
    logic [15:0] m0, m1, m2;
    logic        exp_err;
    logic        hold;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl [6];

  spike_volley_if #(.NUM_CHANNELS(NC), .TIME_W(TW)) bus ();

  spike_volley_encoder #(
    .NUM_CHANNELS(NC), .TIME_W(TW), .GAMMA_PERIOD(GP), .REST_CYCLES(RC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic times_t set_ch(input times_t v, input int ch, input int t);
    v[ch*TW +: TW] = TW'(t);
    return v;
  endfunction

  function automatic vec_t mk(input times_t times, input int t0, input logic [15:0] m0,
                              input int t1, input logic [15:0] m1,
                              input int t2, input logic [15:0] m2,
                              input logic exp_err, input logic hold);
    vec_t v;
    v.times = times; v.t0 = t0; v.m0 = m0; v.t1 = t1; v.m1 = m1; v.t2 = t2; v.m2 = m2;
    v.exp_err = exp_err; v.hold = hold;
    return v;
  endfunction

  // Called at a negedge with the DUT idle; leaves at the first IDLE cycle after REST.
  task automatic run_volley(input int idx);
    vec_t        v;
    logic [15:0] exp;
    v = tbl[idx];
    check($sformatf("v%0d_ready_before", idx), 32'(bus.load_ready), 32'd1);
    bus.spike_times = v.times;
    bus.load_valid  = 1'b1;
    @(negedge clk);
    if (v.hold) bus.spike_times = tbl[idx+1].times;
    else        bus.load_valid  = 1'b0;
    for (int k = 0; k < GP; k++) begin
      exp = '0;
      if (k == v.t0) exp |= v.m0;
      if (k == v.t1) exp |= v.m1;
      if (k == v.t2) exp |= v.m2;
      check($sformatf("v%0d_t%0d_time", idx, k),   32'(bus.time_val), 32'(k));
      check($sformatf("v%0d_t%0d_spikes", idx, k), 32'(bus.spike_volley), 32'(exp));
      check($sformatf("v%0d_t%0d_active", idx, k), 32'(bus.volley_active), 32'd1);
      check($sformatf("v%0d_t%0d_done", idx, k),   32'(bus.cycle_done), 32'(k == GP-1));
      check($sformatf("v%0d_t%0d_ready", idx, k),  32'(bus.load_ready), 32'd0);
      check($sformatf("v%0d_t%0d_err", idx, k),    32'(bus.range_err), 32'(v.exp_err));
      @(negedge clk);
    end
    for (int r = 0; r < RC; r++) begin
      check($sformatf("v%0d_rest%0d_quiet", idx, r),
            {bus.spike_volley, 13'(bus.time_val), bus.volley_active, bus.cycle_done}, 32'd0);
      check($sformatf("v%0d_rest%0d_ready", idx, r), 32'(bus.load_ready), 32'd0);
      @(negedge clk);
    end
    check($sformatf("v%0d_ready_after", idx), 32'(bus.load_ready), 32'd1);
  endtask

  initial begin
    times_t tv;
    bus.load_valid  = 1'b0;
    bus.abort       = 1'b0;
    bus.spike_times = '1;

    // ch0=3, ch1=0, ch3=15
    tv = '1; tv = set_ch(tv, 0, 3); tv = set_ch(tv, 1, 0); tv = set_ch(tv, 3, 15);
    tbl[0] = mk(tv, 0, 16'h0002, 3, 16'h0001, 15, 16'h0008, 1'b0, 1'b0);
    // ch4, ch5, ch9 all at 7
    tv = '1; tv = set_ch(tv, 4, 7); tv = set_ch(tv, 5, 7); tv = set_ch(tv, 9, 7);
    tbl[1] = mk(tv, 7, 16'h0230, -1, 16'h0, -1, 16'h0, 1'b0, 1'b0);
    // ch1=20 is out of range and must never fire
    tv = '1; tv = set_ch(tv, 1, 20); tv = set_ch(tv, 2, 5);
    tbl[2] = mk(tv, 5, 16'h0004, -1, 16'h0, -1, 16'h0, 1'b1, 1'b0);
    // clean volley; error flag stays sticky
    tv = '1; tv = set_ch(tv, 15, 1); tv = set_ch(tv, 8, 12);
    tbl[3] = mk(tv, 1, 16'h8000, 12, 16'h0100, -1, 16'h0, 1'b1, 1'b0);
    // back-to-back pair: load_valid held through RUN/REST of the first
    tv = '1; tv = set_ch(tv, 6, 2);
    tbl[4] = mk(tv, 2, 16'h0040, -1, 16'h0, -1, 16'h0, 1'b1, 1'b1);
    tv = '1; tv = set_ch(tv, 0, 0); tv = set_ch(tv, 15, 15);
    tbl[5] = mk(tv, 0, 16'h0001, 15, 16'h8000, -1, 16'h0, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    check("reset_quiet",
          {bus.spike_volley, 13'(bus.time_val), bus.volley_active, bus.cycle_done}, 32'd0);
    check("reset_err", 32'(bus.range_err), 32'd0);
    check("reset_ready", 32'(bus.load_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_volley(i);

    // Abort at t=6 with ch0=10: ch0 must never fire and no cycle_done.
    tv = '1; tv = set_ch(tv, 0, 10);
    bus.spike_times = tv;
    bus.load_valid  = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_t6_time", 32'(bus.time_val), 32'd6);
    bus.abort = 1'b1;
    @(negedge clk);
    check("abort_quiet",
          {bus.spike_volley, 13'(bus.time_val), bus.volley_active, bus.cycle_done}, 32'd0);
    check("abort_ready", 32'(bus.load_ready), 32'd1);
    // abort held while idle changes nothing
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("abort_idle%0d", c),
            {bus.spike_volley, bus.volley_active, bus.cycle_done, bus.load_ready}, 32'd1);
    end
    // abort + load together in IDLE: load wins; abort then cancels the RUN
    tv = '1; tv = set_ch(tv, 0, 0);
    bus.spike_times = tv;
    bus.load_valid  = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    check("abort_load_active", 32'(bus.volley_active), 32'd1);
    check("abort_load_spikes", 32'(bus.spike_volley), 32'h0001);
    check("abort_load_ready", 32'(bus.load_ready), 32'd0);
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_run_active", 32'(bus.volley_active), 32'd0);
    check("abort_run_ready", 32'(bus.load_ready), 32'd1);

    // Reset at t=4 mid-RUN: outputs drop before the next clock edge.
    tv = '1; tv = set_ch(tv, 0, 4);
    bus.spike_times = tv;
    bus.load_valid  = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_pre_time", 32'(bus.time_val), 32'd4);
    check("rst_pre_spikes", 32'(bus.spike_volley), 32'h0001);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_quiet",
          {bus.spike_volley, 13'(bus.time_val), bus.volley_active, bus.cycle_done}, 32'd0);
    check("rst_async_err", 32'(bus.range_err), 32'd0);
    check("rst_async_ready", 32'(bus.load_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < GP + 2; c++) begin
      @(negedge clk);
      check($sformatf("rst_after%0d", c),
            {bus.spike_volley, bus.volley_active, bus.cycle_done, bus.load_ready}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spike_volley_encoder.md
Name: spike_volley_encoder

Overview:
- Temporal-code transmitter for the clocked STDP column; produces the `spike_volley` / `time_val` stream that the column's winner-take-all stage consumes.
- Accepts one vector of per-channel spike times through a valid/ready load.
- Replays that vector over one gamma cycle as single-cycle spikes.
- Follows each gamma cycle with a rest window so downstream neurons and inhibition can clear state.

Parameters:
- NUM_CHANNELS, 16: number of spike lines; equals neurons_per_layer.
- TIME_W, 5: width of each spike time and of `time_val`.
- GAMMA_PERIOD, 16: time steps per gamma cycle; valid spike times are 0..GAMMA_PERIOD-1.
- REST_CYCLES, 4: idle cycles after each gamma cycle; must be at least 1.
- NULL_TIME, all-ones of TIME_W (31): encodes "channel never spikes".

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  spike_times vector is presented.
- load_ready  out  1  encoder can accept a vector.
- spike_times  in  NUM_CHANNELS*TIME_W  channel i occupies bits [i*TIME_W +: TIME_W].
- abort  in  1  synchronous cancel of the current volley.
- time_val  out  TIME_W  current time step within the gamma cycle.
- spike_volley  out  NUM_CHANNELS  one-hot-per-channel spike pulses for this time step.
- volley_active  out  1  high while time_val/spike_volley are meaningful (RUN state).
- cycle_done  out  1  one-cycle pulse on the final RUN step.
- range_err  out  1  sticky flag: a loaded time was non-NULL and >= GAMMA_PERIOD.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, `time_val`=0, `spike_volley`=0, `volley_active`=0, `cycle_done`=0, `range_err`=0, stored times all NULL_TIME, rest counter 0.
- `load_ready` = 1 only in IDLE (combinational from state). All other outputs are registered.
- State IDLE:
  - `load_valid & load_ready` at edge N: capture `spike_times` into internal registers, go to RUN.
  - At edge N the output registers load `time_val`=0, `volley_active`=1, and the step-0 spikes. The first volley is therefore visible on cycle N+1 (1-cycle latency).
- State RUN:
  - Each cycle, `spike_volley[i]`=1 iff stored_time[i] == `time_val` and stored_time[i] != NULL_TIME.
  - Each channel fires at most once per gamma cycle.
  - Multiple channels may fire on the same step; no priority is applied here.
  - `time_val` increments by 1 per clock.
  - When `time_val` == GAMMA_PERIOD-1: `cycle_done`=1 for that cycle. Next edge: go to REST, `time_val`=0, `spike_volley`=0, `volley_active`=0.
- State REST:
  - Counts REST_CYCLES clocks with all outputs quiet, then returns to IDLE.
  - `load_valid` during RUN or REST is ignored (`load_ready`=0). The producer holds it.
- Range check:
  - A captured time that is non-NULL and >= GAMMA_PERIOD never fires.
  - Capturing such a time sets `range_err` at the capture edge.
  - `range_err` clears only on reset.
- Abort:
  - `abort` high in RUN or REST: next edge goes to IDLE with `spike_volley`=0, `volley_active`=0, `time_val`=0, and no `cycle_done`.
  - `abort` in IDLE has no effect.
  - `abort` and `load_valid` together in IDLE: the load is taken and abort is ignored.
- Arithmetic:
  - `time_val` never exceeds GAMMA_PERIOD-1.
  - Compares are unsigned, full TIME_W width.
  - GAMMA_PERIOD <= NULL_TIME is required (elaboration-time check).
- Throughput: one volley per GAMMA_PERIOD+REST_CYCLES+1 cycles minimum.
- Reset asserted mid-RUN: outputs drop immediately (asynchronously); no partial `cycle_done`.

Test Plan:
- Reset then load ch0=3, ch1=0, ch2=NULL, ch3=15 (others NULL):
  - `time_val` 0..15 on cycles N+1..N+16.
  - `spike_volley`=0x0002 at t=0, 0x0001 at t=3, 0x0008 at t=15, zero elsewhere.
  - `cycle_done` only at t=15.
  - `load_ready` low for 16+4 cycles, then high.
- Load ch4=7, ch5=7, ch9=7 -> `spike_volley`=0x0230 on t=7 only; no other spikes.
- Load ch1=20 (out of range), ch2=5 -> ch1 never fires; ch2 fires at t=5; `range_err`=1 from capture and still 1 after a second clean volley.
- Back-to-back: `load_valid` held high continuously with a new vector -> second capture occurs exactly 1 cycle after REST ends; the second vector is not sampled during RUN/REST.
- Abort at t=6 with ch0=10 -> ch0 never fires; no `cycle_done`; IDLE and `load_ready`=1 on the next cycle.
- Deassert `rst_n` at t=4 mid-RUN -> all outputs 0 asynchronously. After release: `load_ready`=1, stored times NULL, and no spikes until a new load.
